full_tap_arb: RTL and testbench
===============================

// Module: full_tap_arb
// PURPOSE
//  Arbitrates the single-port tap memory (tap_int, 192b x 16) among three requesters:
//  host tap load (ld), forward-pass tap read (fwd), error-update read-modify-write (upd).
//  Sits between full_st0_ctrl_out_ctrl/error path and the tap RAM wrapper.
//  Guarantees one access per cycle, fairness fwd/upd, atomic RMW, and tagged read return.
// PARAMETERS
//  DATA_W    192  tap word width
//  ADDR_W    4    tap address width
//  RD_LAT    1    RAM read latency (cycles from registered cmd to rd_data), 1..3
//  LD_BURST  4    max consecutive ld grants while fwd/upd pending
// PORTS
//  clk           in   1       clock
//  reset         in   1       synchronous, active-high reset
//  ld_req        in   1       host write request (write-only)
//  ld_addr       in   ADDR_W  host write address
//  ld_wdata      in   DATA_W  host write data
//  ld_gnt        out  1       ld accepted this cycle
//  fwd_req       in   1       forward read request (read-only)
//  fwd_addr      in   ADDR_W  forward read address
//  fwd_gnt       out  1       fwd accepted this cycle
//  fwd_rd_vld    out  1       rd_data belongs to fwd
//  upd_req       in   1       update request
//  upd_wr        in   1       1=write, 0=read
//  upd_lock      in   1       with read: start atomic RMW
//  upd_addr      in   ADDR_W  update address
//  upd_wdata     in   DATA_W  update write data
//  upd_gnt       out  1       upd accepted this cycle
//  upd_rd_vld    out  1       rd_data belongs to upd
//  rd_data       out  DATA_W  read data (passthrough of tap_int_rd_data)
//  tap_int_en    out  1       RAM access enable (registered)
//  tap_int_wr    out  1       RAM write strobe (registered)
//  tap_int_addr  out  ADDR_W  RAM address (registered)
//  tap_int_wr_data out DATA_W RAM write data (registered)
//  tap_int_rd_data in DATA_W  RAM read data
// BEHAVIOUR
//  - Handshake: req held stable (addr/data/wr) until gnt; gnt combinational from req+state;
//    transfer when req&gnt. At most one gnt per cycle.
//  - Priority: lock owner upd > ld > round-robin(fwd,upd). rr pointer toggles to the
//    other requester after each fwd/upd grant; reset value favours fwd.
//  - LD burst: ld_cnt counts consecutive ld grants; at LD_BURST with fwd|upd pending,
//    next slot goes to rr winner, ld_cnt clears. ld_cnt clears on any non-ld cycle.
//  - Lock FSM: IDLE -> LOCKED on upd read grant with upd_lock=1. In LOCKED only upd is
//    grantable (ld, fwd gnt=0). LOCKED -> IDLE on upd write grant. upd read in LOCKED ok.
//  - Cmd register: granted cmd appears on tap_int_* cycle N+1; en=0 when no grant.
//  - Read return: tag pipe RD_LAT+1 deep; fwd_rd_vld/upd_rd_vld assert exactly
//    RD_LAT+1 cycles after read gnt (cycle N+1+RD_LAT); rd_data valid only then.
//    Back-to-back reads return in grant order, one per cycle, no bubbles.
//  - Ordering: accesses hit RAM in grant order; write then read same addr returns new data.
//  - Reset (incl. mid-operation): all gnt/vld/tap_int_en/tap_int_wr=0, addr/wr_data=0,
//    FSM IDLE, rr->fwd, ld_cnt=0, tag pipe flushed (in-flight reads discarded, no vld).
//  - Illegal: upd_wr=1 with upd_lock=1 treated as plain write (lock ignored).
// STRUCTURE
//  - Shared package: tap_arb_src_e {SRC_NONE,SRC_LD,SRC_FWD,SRC_UPD}; tap_arb_cmd_t
//    {en,wr,addr,wdata}; lock_state_e {LK_IDLE,LK_LOCKED}.
//  - Sub-module full_tap_arb_rdpipe: RD_LAT+1 stage shift of tap_arb_src_e read tags ->
//    per-requester rd_vld. Arbitration/FSM/cmd register in top.
// TESTING
//  1 fwd reads addr 0..15 back-to-back, RD_LAT=1 -> fwd_gnt every cycle, fwd_rd_vld 2 cyc
//    later, rd_data = preloaded word[i] in order.
//  2 fwd_req & upd_req held 8 cyc -> grants alternate fwd,upd,fwd,... (4 each).
//  3 ld_req held 10 cyc with fwd_req pending, LD_BURST=4 -> ld x4, fwd x1, ld x4, fwd x1.
//  4 upd lock read addr 5, fwd_req+ld_req active -> only upd gnt until upd write addr 5
//    value+1; then fwd read addr 5 returns value+1.
//  5 reset asserted 1 cyc after fwd read gnt -> no fwd_rd_vld, all outputs 0 next cycle.
//  6 ld write addr 3 = 0xA5.., next cycle fwd read addr 3 -> rd_data 0xA5.. at vld.

Source files
------------

// File: rtl/full_tap_arb_pkg.sv
// full_tap_arb_pkg: shared types for the tap memory arbiter
package full_tap_arb_pkg;
  localparam int TAP_DATA_W = 192;
  localparam int TAP_ADDR_W = 4;
  typedef enum logic [1:0] {SRC_NONE, SRC_LD, SRC_FWD, SRC_UPD} tap_arb_src_e;
  typedef struct packed {
    logic                  en;
    logic                  wr;
    logic [TAP_ADDR_W-1:0] addr;
    logic [TAP_DATA_W-1:0] wdata;
  } tap_arb_cmd_t;
  typedef enum logic {LK_IDLE, LK_LOCKED} lock_state_e;
endpackage

// File: rtl/full_tap_arb_rdpipe.sv
// full_tap_arb_rdpipe: delays read tags to the cycle their data leaves the RAM
module full_tap_arb_rdpipe
  import full_tap_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  tap_arb_src_e i_tag,
  output logic         o_fwd_vld,
  output logic         o_upd_vld
);
  tap_arb_src_e r_pipe [DEPTH];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= SRC_NONE;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign o_fwd_vld = r_pipe[DEPTH-1] == SRC_FWD;
  assign o_upd_vld = r_pipe[DEPTH-1] == SRC_UPD;
endmodule

// File: rtl/full_tap_arb.sv
// full_tap_arb: single-port tap RAM arbiter for host load, forward read and update RMW
module full_tap_arb
  import full_tap_arb_pkg::*;
#(
  parameter int DATA_W   = TAP_DATA_W,
  parameter int ADDR_W   = TAP_ADDR_W,
  parameter int RD_LAT   = 1,
  parameter int LD_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              fwd_req,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_gnt,
  output logic              fwd_rd_vld,
  input  logic              upd_req,
  input  logic              upd_wr,
  input  logic              upd_lock,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_wdata,
  output logic              upd_gnt,
  output logic              upd_rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              tap_int_en,
  output logic              tap_int_wr,
  output logic [ADDR_W-1:0] tap_int_addr,
  output logic [DATA_W-1:0] tap_int_wr_data,
  input  logic [DATA_W-1:0] tap_int_rd_data
);
  localparam int CW = $clog2(LD_BURST + 1);
  lock_state_e  r_lock, w_lock_nxt;
  logic         r_rr;
  logic [CW-1:0] r_ld_cnt;
  tap_arb_cmd_t r_cmd, w_cmd;
  tap_arb_src_e w_tag;
  logic         w_locked, w_ld_ok;
  // r_rr=1 means upd wins the next fwd/upd contest
  always_comb begin
    w_locked   = r_lock == LK_LOCKED;
    w_ld_ok    = ld_req && !(r_ld_cnt >= CW'(LD_BURST) && (fwd_req || upd_req));
    ld_gnt     = !reset && !w_locked && w_ld_ok;
    fwd_gnt    = !reset && !w_locked && !w_ld_ok && fwd_req && !(upd_req && r_rr);
    upd_gnt    = !reset && upd_req && (w_locked || (!w_ld_ok && !(fwd_req && !r_rr)));
    w_cmd.en   = ld_gnt || fwd_gnt || upd_gnt;
    w_cmd.wr   = ld_gnt || (upd_gnt && upd_wr);
    w_cmd.addr = ld_gnt ? ld_addr : fwd_gnt ? fwd_addr : upd_gnt ? upd_addr : '0;
    w_cmd.wdata = ld_gnt ? ld_wdata : (upd_gnt && upd_wr) ? upd_wdata : '0;
    w_tag      = fwd_gnt ? SRC_FWD : (upd_gnt && !upd_wr) ? SRC_UPD : SRC_NONE;
    w_lock_nxt = (upd_gnt && upd_wr) ? LK_IDLE :
                 (upd_gnt && upd_lock) ? LK_LOCKED : r_lock;
  end
  always_ff @(posedge clk) begin
    if (reset) r_lock <= LK_IDLE;
    else r_lock <= w_lock_nxt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr     <= 1'b0;
      r_ld_cnt <= '0;
      r_cmd    <= '0;
    end else begin
      r_rr     <= upd_gnt ? 1'b0 : fwd_gnt ? 1'b1 : r_rr;
      r_ld_cnt <= !ld_gnt ? '0 : (r_ld_cnt == CW'(LD_BURST)) ? r_ld_cnt : r_ld_cnt + CW'(1);
      r_cmd    <= w_cmd;
    end
  end
  assign tap_int_en      = r_cmd.en;
  assign tap_int_wr      = r_cmd.wr;
  assign tap_int_addr    = r_cmd.addr;
  assign tap_int_wr_data = r_cmd.wdata;
  assign rd_data         = tap_int_rd_data;
  full_tap_arb_rdpipe #(.DEPTH(RD_LAT + 1)) u_rdpipe (
    .clk      (clk),
    .reset    (reset),
    .i_tag    (w_tag),
    .o_fwd_vld(fwd_rd_vld),
    .o_upd_vld(upd_rd_vld)
  );
endmodule

// File: tb/tb_full_tap_arb.sv
// tb_full_tap_arb: scenario and randomized checks of full_tap_arb against a grant/RAM model
module tb_full_tap_arb;
  import full_tap_arb_pkg::*;
  localparam int DW = 192, AW = 4, RD_LAT = 1, LD_BURST = 4, LAT = RD_LAT + 1;
  logic clk = 1'b0, reset = 1'b1;
  logic ld_req = 0, fwd_req = 0, upd_req = 0, upd_wr = 0, upd_lock = 0;
  logic [AW-1:0] ld_addr = '0, fwd_addr = '0, upd_addr = '0;
  logic [DW-1:0] ld_wdata = '0, upd_wdata = '0;
  logic ld_gnt, fwd_gnt, upd_gnt, fwd_rd_vld, upd_rd_vld;
  logic [DW-1:0] rd_data, tap_int_wr_data, ram_q;
  logic tap_int_en, tap_int_wr;
  logic [AW-1:0] tap_int_addr;
  logic [DW-1:0] ram [16];
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [DW-1:0] init_w [16];
  logic [DW-1:0] m_mem [16];
  bit m_locked, m_fav_upd, m_en, m_wr;
  int m_streak;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  typedef struct {int due; bit fwd; logic [DW-1:0] data;} ret_t;
  ret_t rq[$];

  always #5 clk = ~clk;

  full_tap_arb #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RD_LAT), .LD_BURST(LD_BURST)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .fwd_req(fwd_req), .fwd_addr(fwd_addr), .fwd_gnt(fwd_gnt), .fwd_rd_vld(fwd_rd_vld),
    .upd_req(upd_req), .upd_wr(upd_wr), .upd_lock(upd_lock), .upd_addr(upd_addr),
    .upd_wdata(upd_wdata), .upd_gnt(upd_gnt), .upd_rd_vld(upd_rd_vld), .rd_data(rd_data),
    .tap_int_en(tap_int_en), .tap_int_wr(tap_int_wr), .tap_int_addr(tap_int_addr),
    .tap_int_wr_data(tap_int_wr_data), .tap_int_rd_data(ram_q)
  );

  always @(posedge clk) begin
    if (tap_int_en) begin
      if (tap_int_wr) ram[tap_int_addr] <= tap_int_wr_data;
      else ram_q <= ram[tap_int_addr];
    end
  end

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // 0 none, 1 ld, 2 fwd, 3 upd
  function automatic int exp_who();
    if (reset) return 0;
    if (m_locked) return upd_req ? 3 : 0;
    if (ld_req && !(m_streak >= LD_BURST && (fwd_req || upd_req))) return 1;
    if (fwd_req && upd_req) return m_fav_upd ? 3 : 2;
    if (fwd_req) return 2;
    if (upd_req) return 3;
    return 0;
  endfunction

  task automatic tick();
    int w;
    w = exp_who();
    if (reset) begin
      m_locked = 0; m_fav_upd = 0; m_streak = 0; rq.delete();
      m_en = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    end else begin
      m_streak = (w == 1) ? m_streak + 1 : 0;
      if (w == 2) m_fav_upd = 1;
      if (w == 3) m_fav_upd = 0;
      m_en = w != 0;
      m_wr = (w == 1) || (w == 3 && upd_wr);
      m_addr = '0;
      if (w == 1) m_addr = ld_addr;
      if (w == 2) m_addr = fwd_addr;
      if (w == 3) m_addr = upd_addr;
      m_wdata = (w == 1) ? ld_wdata : (w == 3 && upd_wr) ? upd_wdata : '0;
      if (m_wr) m_mem[m_addr] = m_wdata;
      else if (m_en) rq.push_back('{cyc + LAT, w == 2, m_mem[m_addr]});
      if (w == 3 && upd_wr) m_locked = 0;
      else if (w == 3 && upd_lock) m_locked = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
  endtask

  task automatic idle();
    ld_req = 0; fwd_req = 0; upd_req = 0; upd_wr = 0; upd_lock = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    tick(); tick();
    ld_req = 1; fwd_req = 1; upd_req = 1;
    #1;
    n_tests++;
    if ({ld_gnt, fwd_gnt, upd_gnt, fwd_rd_vld, upd_rd_vld} !== 5'b0) begin
      n_fail++; $display("FAIL reset_out got %b exp 00000", {ld_gnt, fwd_gnt, upd_gnt, fwd_rd_vld, upd_rd_vld});
    end
    n_tests++;
    if ({tap_int_en, tap_int_wr, tap_int_addr} !== '0 || tap_int_wr_data !== '0) begin
      n_fail++; $display("FAIL reset_cmd got en=%b wr=%b addr=%h exp all 0", tap_int_en, tap_int_wr, tap_int_addr);
    end
    idle(); tick(); reset = 0;
  endtask

  task automatic test_preload();
    for (int k = 0; k < 16; k++) begin
      ld_req = 1; ld_addr = AW'(k); ld_wdata = rnd_word(); init_w[k] = ld_wdata;
      #1;
      n_tests++;
      if (ld_gnt !== 1'b1) begin n_fail++; $display("FAIL preload_gnt k=%0d got %b exp 1", k, ld_gnt); end
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_fwd_stream();
    for (int k = 0; k < 16 + LAT; k++) begin
      fwd_req = k < 16; fwd_addr = AW'(k);
      #1;
      n_tests++;
      if (fwd_gnt !== (k < 16)) begin n_fail++; $display("FAIL fwd_stream_gnt k=%0d got %b exp %b", k, fwd_gnt, k < 16); end
      n_tests++;
      if (fwd_rd_vld !== (k >= LAT)) begin n_fail++; $display("FAIL fwd_stream_vld k=%0d got %b exp %b", k, fwd_rd_vld, k >= LAT); end
      if (k >= LAT) begin
        n_tests++;
        if (rd_data !== init_w[k-LAT]) begin n_fail++; $display("FAIL fwd_stream_data k=%0d got %h exp %h", k, rd_data, init_w[k-LAT]); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_rr();
    int nf = 0, nu = 0;
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 8; i++) begin
      fwd_req = 1; upd_req = 1; upd_wr = 0; upd_lock = 0;
      fwd_addr = AW'($urandom); upd_addr = AW'($urandom);
      #1;
      n_tests++;
      if (fwd_gnt !== (i % 2 == 0) || upd_gnt !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL rr_alt i=%0d got fwd=%b upd=%b exp fwd=%b", i, fwd_gnt, upd_gnt, i % 2 == 0);
      end
      nf += int'(fwd_gnt); nu += int'(upd_gnt);
      tick();
    end
    n_tests++;
    if (nf != 4 || nu != 4) begin n_fail++; $display("FAIL rr_count got fwd=%0d upd=%0d exp 4/4", nf, nu); end
    idle(); tick(); tick();
  endtask

  task automatic test_ld_burst();
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 10; i++) begin
      ld_req = 1; ld_addr = AW'($urandom); ld_wdata = rnd_word();
      fwd_req = 1; fwd_addr = AW'($urandom);
      #1;
      n_tests++;
      if (ld_gnt !== (i % 5 != 4) || fwd_gnt !== (i % 5 == 4)) begin
        n_fail++; $display("FAIL ld_burst i=%0d got ld=%b fwd=%b exp ld=%b", i, ld_gnt, fwd_gnt, i % 5 != 4);
      end
      tick();
    end
    idle(); tick(); tick();
  endtask

  task automatic test_lock();
    logic [DW-1:0] v;
    int gc = -1;
    bit g;
    reset = 1; tick(); reset = 0;
    v = m_mem[5];
    upd_req = 1; upd_wr = 0; upd_lock = 1; upd_addr = 5;
    #1;
    n_tests++;
    if (upd_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_rd_gnt got %b exp 1", upd_gnt); end
    tick();
    upd_req = 0; upd_lock = 0;
    ld_req = 1; ld_addr = 9; ld_wdata = rnd_word(); fwd_req = 1; fwd_addr = 5;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (ld_gnt !== 1'b0 || fwd_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_block i=%0d got ld=%b fwd=%b exp 0/0", i, ld_gnt, fwd_gnt); end
      if (i == LAT - 1) begin
        n_tests++;
        if (upd_rd_vld !== 1'b1 || rd_data !== v) begin n_fail++; $display("FAIL lock_rd_data got vld=%b %h exp 1 %h", upd_rd_vld, rd_data, v); end
      end
      tick();
    end
    upd_req = 1; upd_wr = 1; upd_wdata = v + 1;
    #1;
    n_tests++;
    if (upd_gnt !== 1'b1 || ld_gnt !== 1'b0 || fwd_gnt !== 1'b0) begin
      n_fail++; $display("FAIL lock_wr_gnt got upd=%b ld=%b fwd=%b exp 1/0/0", upd_gnt, ld_gnt, fwd_gnt);
    end
    tick();
    upd_req = 0; upd_wr = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (fwd_gnt && gc < 0) gc = i;
      if (gc >= 0 && i == gc + LAT) begin
        n_tests++;
        if (fwd_rd_vld !== 1'b1 || rd_data !== v + 1) begin n_fail++; $display("FAIL lock_fwd_data got vld=%b %h exp 1 %h", fwd_rd_vld, rd_data, v + 1); end
      end
      g = fwd_gnt;
      tick();
      if (g) fwd_req = 0;
    end
    n_tests++;
    if (gc < 0) begin n_fail++; $display("FAIL lock_fwd_timeout got no fwd_gnt exp grant within 20 cycles"); end
    idle(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    reset = 1; tick(); reset = 0;
    fwd_req = 1; fwd_addr = 7;
    #1;
    n_tests++;
    if (fwd_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt got %b exp 1", fwd_gnt); end
    tick();
    fwd_req = 0; ld_req = 1; reset = 1;
    #1;
    n_tests++;
    if ({ld_gnt, fwd_gnt, upd_gnt} !== 3'b0) begin n_fail++; $display("FAIL rstmid_gnt0 got %b exp 000", {ld_gnt, fwd_gnt, upd_gnt}); end
    tick();
    reset = 0; ld_req = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if ({fwd_rd_vld, upd_rd_vld, tap_int_en, tap_int_wr} !== 4'b0 || tap_int_addr !== '0 || tap_int_wr_data !== '0) begin
        n_fail++; $display("FAIL rstmid_out i=%0d got vld=%b%b en=%b wr=%b addr=%h exp all 0", i, fwd_rd_vld, upd_rd_vld, tap_int_en, tap_int_wr, tap_int_addr);
      end
      tick();
    end
  endtask

  task automatic test_wr_rd();
    logic [DW-1:0] a5;
    a5 = {24{8'hA5}};
    reset = 1; tick(); reset = 0;
    ld_req = 1; ld_addr = 3; ld_wdata = a5;
    #1;
    n_tests++;
    if (ld_gnt !== 1'b1) begin n_fail++; $display("FAIL wrrd_ld_gnt got %b exp 1", ld_gnt); end
    tick();
    ld_req = 0; fwd_req = 1; fwd_addr = 3;
    #1;
    n_tests++;
    if (fwd_gnt !== 1'b1) begin n_fail++; $display("FAIL wrrd_fwd_gnt got %b exp 1", fwd_gnt); end
    tick();
    fwd_req = 0;
    #1;
    n_tests++;
    if (fwd_rd_vld !== 1'b0) begin n_fail++; $display("FAIL wrrd_early_vld got %b exp 0", fwd_rd_vld); end
    tick();
    #1;
    n_tests++;
    if (fwd_rd_vld !== 1'b1 || rd_data !== a5) begin n_fail++; $display("FAIL wrrd_data got vld=%b %h exp 1 %h", fwd_rd_vld, rd_data, a5); end
    tick();
  endtask

  task automatic test_random();
    int w;
    bit ef, eu;
    logic [DW-1:0] ed;
    reset = 1; idle(); tick(); reset = 0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      #1;
      w = exp_who();
      n_tests++;
      if ({ld_gnt, fwd_gnt, upd_gnt} !== {w == 1, w == 2, w == 3}) begin
        n_fail++; $display("FAIL rand_gnt c=%0d got %b exp %b", c, {ld_gnt, fwd_gnt, upd_gnt}, {w == 1, w == 2, w == 3});
      end
      ef = rq.size() > 0 && rq[0].due == cyc && rq[0].fwd;
      eu = rq.size() > 0 && rq[0].due == cyc && !rq[0].fwd;
      ed = (ef || eu) ? rq[0].data : '0;
      n_tests++;
      if (fwd_rd_vld !== ef || upd_rd_vld !== eu || ((ef || eu) && rd_data !== ed)) begin
        n_fail++; $display("FAIL rand_ret c=%0d got vld=%b%b %h exp %b%b %h", c, fwd_rd_vld, upd_rd_vld, rd_data, ef, eu, ed);
      end
      n_tests++;
      if (tap_int_en !== m_en || tap_int_wr !== m_wr || tap_int_addr !== m_addr || tap_int_wr_data !== m_wdata) begin
        n_fail++; $display("FAIL rand_cmd c=%0d got en=%b wr=%b addr=%h exp en=%b wr=%b addr=%h", c, tap_int_en, tap_int_wr, tap_int_addr, m_en, m_wr, m_addr);
      end
      tick();
      if (w == 1 || !ld_req) begin
        ld_req = $urandom_range(0, 2) == 0; ld_addr = AW'($urandom); ld_wdata = rnd_word();
      end
      if (w == 2 || !fwd_req) begin
        fwd_req = $urandom_range(0, 1) == 0; fwd_addr = AW'($urandom);
      end
      if (w == 3 || !upd_req) begin
        upd_req = $urandom_range(0, 1) == 0; upd_wr = $urandom_range(0, 2) == 0;
        upd_lock = $urandom_range(0, 3) == 0; upd_addr = AW'($urandom); upd_wdata = rnd_word();
      end
    end
    reset = 0; idle(); tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_preload();
    test_fwd_stream();
    test_rr();
    test_ld_burst();
    test_lock();
    test_reset_mid();
    test_wr_rd();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
